hdr_fb_scheduler: RTL and testbench

- Frame-buffer scheduler for the real-time HDR video path, in the pixel_clk domain.
- Manages NUM_BUF frame-buffer slots shared by two clients:
  - the sensor writer, which captures a long-exposure then a short-exposure frame into one slot;
  - the HDMI reader, which fetches one merged slot per output frame.
- Decides which slot each side uses, drives the exposure select for sensor configuration, and reports dropped and repeated frames.

---
 rtl/hdr_fb_pkg.sv | 23 ++
 rtl/fb_free_finder.sv | 23 ++
 rtl/hdr_fb_scheduler.sv | 161 ++++++++++++++++
 tb/tb_hdr_fb_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hdr_fb_pkg.sv
// Shared types and constants for the HDR frame-buffer scheduler.
package hdr_fb_pkg;

    typedef enum logic [1:0] {
        FREE,
        WRITING,
        READY,
        READING
    } buf_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_LONG,
        W_GAP,
        W_SHORT
    } wr_state_t;

    localparam logic EXP_LONG  = 1'b0;
    localparam logic EXP_SHORT = 1'b1;

    localparam int unsigned MAX_BUF = 8;

endpackage

// File: rtl/fb_free_finder.sv
// Lowest-index FREE slot priority encoder.
module fb_free_finder #(
    parameter  int unsigned NUM_BUF = 3,
    localparam int unsigned BUF_W   = $clog2(NUM_BUF)
) (
    input  logic [NUM_BUF-1:0] free_mask,
    output logic [BUF_W-1:0]   idx,
    output logic               any_free
);

    // Scan downward so the lowest free index is the last one written.
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int unsigned i = NUM_BUF; i > 0; i--) begin
            if (free_mask[i-1]) begin
                idx      = BUF_W'(i - 1);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdr_fb_scheduler.sv
// Frame-buffer slot scheduler between the HDR sensor writer and the HDMI reader.
module hdr_fb_scheduler
    import hdr_fb_pkg::*;
#(
    parameter  int unsigned NUM_BUF = 3,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned BUF_W   = $clog2(NUM_BUF)
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             wr_sof,
    input  logic             wr_eof,
    input  logic             wr_abort,
    input  logic             rd_sof,
    output logic [BUF_W-1:0] wr_buf,
    output logic             wr_exp,
    output logic             wr_active,
    output logic [BUF_W-1:0] rd_buf,
    output logic             rd_valid,
    output logic             frame_dropped,
    output logic             frame_repeated,
    output logic             proto_err,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] rep_cnt
);

    buf_state_t slot     [NUM_BUF];
    buf_state_t slot_nxt [NUM_BUF];
    wr_state_t  wr_state;

    logic [NUM_BUF-1:0] free_mask;
    logic [BUF_W-1:0]   free_idx;
    logic               any_free;
    logic [BUF_W-1:0]   ready_idx;
    logic [BUF_W-1:0]   reading_idx;
    logic [BUF_W-1:0]   take_idx;
    logic               ready_any;
    logic               reading_any;

    logic ev_abort, ev_claim, ev_restart, ev_long_done, ev_gap_sof, ev_commit;
    logic ev_perr, ev_drop, ev_take, ev_rep;

    always_comb begin
        free_mask   = '0;
        ready_any   = 1'b0;
        ready_idx   = '0;
        reading_any = 1'b0;
        reading_idx = '0;
        for (int unsigned i = 0; i < NUM_BUF; i++) begin
            free_mask[i] = (slot[i] == FREE);
            if (slot[i] == READY) begin
                ready_any = 1'b1;
                ready_idx = BUF_W'(i);
            end
            if (slot[i] == READING) begin
                reading_any = 1'b1;
                reading_idx = BUF_W'(i);
            end
        end
    end

    fb_free_finder #(
        .NUM_BUF (NUM_BUF)
    ) u_free_finder (
        .free_mask (free_mask),
        .idx       (free_idx),
        .any_free  (any_free)
    );

    // Writer events; abort outranks sof/eof, and sof outranks eof.
    always_comb begin
        ev_abort     = wr_abort && (wr_state != W_IDLE);
        ev_claim     = !ev_abort && (wr_state == W_IDLE) && wr_sof && any_free;
        ev_restart   = !ev_abort && wr_sof && ((wr_state == W_LONG) || (wr_state == W_SHORT));
        ev_long_done = !ev_abort && (wr_state == W_LONG) && !wr_sof && wr_eof;
        ev_gap_sof   = !ev_abort && (wr_state == W_GAP) && wr_sof;
        ev_commit    = !ev_abort && (wr_state == W_SHORT) && !wr_sof && wr_eof;
        ev_perr      = ev_restart ||
                       (!ev_abort && !wr_sof && wr_eof &&
                        ((wr_state == W_IDLE) || (wr_state == W_GAP)));
        ev_drop      = ev_commit && ready_any;
    end

    // A same-cycle commit is visible to the reader before it picks a slot.
    always_comb begin
        take_idx = ev_commit ? wr_buf : ready_idx;
        ev_take  = rd_sof && (ev_commit || ready_any);
        ev_rep   = rd_sof && !ev_take && rd_valid;

        slot_nxt = slot;
        if (ev_abort)
            slot_nxt[wr_buf] = FREE;
        if (ev_claim)
            slot_nxt[free_idx] = WRITING;
        if (ev_drop)
            slot_nxt[ready_idx] = FREE;
        if (ev_commit)
            slot_nxt[wr_buf] = READY;
        if (ev_take) begin
            if (reading_any)
                slot_nxt[reading_idx] = FREE;
            slot_nxt[take_idx] = READING;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            slot           <= '{default: FREE};
            wr_state       <= W_IDLE;
            wr_buf         <= '0;
            wr_exp         <= EXP_LONG;
            wr_active      <= 1'b0;
            rd_buf         <= '0;
            rd_valid       <= 1'b0;
            frame_dropped  <= 1'b0;
            frame_repeated <= 1'b0;
            proto_err      <= 1'b0;
            drop_cnt       <= '0;
            rep_cnt        <= '0;
        end else begin
            slot           <= slot_nxt;
            frame_dropped  <= ev_drop;
            frame_repeated <= ev_rep;
            proto_err      <= ev_perr;

            if (ev_take) begin
                rd_buf   <= take_idx;
                rd_valid <= 1'b1;
            end

            if (ev_drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
            if (ev_rep && (rep_cnt != '1))
                rep_cnt <= rep_cnt + 1'b1;

            if (ev_abort) begin
                wr_state  <= W_IDLE;
                wr_active <= 1'b0;
                wr_exp    <= EXP_LONG;
            end else if (ev_claim) begin
                wr_state  <= W_LONG;
                wr_buf    <= free_idx;
                wr_exp    <= EXP_LONG;
                wr_active <= 1'b1;
            end else if (ev_restart) begin
                wr_state <= W_LONG;
                wr_exp   <= EXP_LONG;
            end else if (ev_long_done) begin
                wr_state <= W_GAP;
            end else if (ev_gap_sof) begin
                wr_state <= W_SHORT;
                wr_exp   <= EXP_SHORT;
            end else if (ev_commit) begin
                wr_state  <= W_IDLE;
                wr_active <= 1'b0;
                wr_exp    <= EXP_LONG;
            end
        end
    end

endmodule

// File: tb/tb_hdr_fb_scheduler.sv
// Directed and randomized checks of hdr_fb_scheduler against a sequential slot model.
module tb_hdr_fb_scheduler;

    localparam int NB = 3;
    localparam int CW = 16;

    // Model slot codes
    localparam int S_FREE    = 0;
    localparam int S_WRITING = 1;
    localparam int S_READY   = 2;
    localparam int S_READING = 3;

    logic          pixel_clk = 1'b0;
    logic          reset     = 1'b1;
    logic          wr_sof    = 1'b0;
    logic          wr_eof    = 1'b0;
    logic          wr_abort  = 1'b0;
    logic          rd_sof    = 1'b0;
    logic [1:0]    wr_buf;
    logic          wr_exp;
    logic          wr_active;
    logic [1:0]    rd_buf;
    logic          rd_valid;
    logic          frame_dropped;
    logic          frame_repeated;
    logic          proto_err;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] rep_cnt;

    int checks = 0;
    int errors = 0;

    int ms [NB];
    int mph, m_wb, m_exp, m_act, m_rb, m_rv, m_drop, m_rep, m_perr, m_dcnt, m_rcnt;

    always #5 pixel_clk = ~pixel_clk;

    hdr_fb_scheduler #(
        .NUM_BUF (NB),
        .CNT_W   (CW)
    ) dut (
        .pixel_clk      (pixel_clk),
        .reset          (reset),
        .wr_sof         (wr_sof),
        .wr_eof         (wr_eof),
        .wr_abort       (wr_abort),
        .rd_sof         (rd_sof),
        .wr_buf         (wr_buf),
        .wr_exp         (wr_exp),
        .wr_active      (wr_active),
        .rd_buf         (rd_buf),
        .rd_valid       (rd_valid),
        .frame_dropped  (frame_dropped),
        .frame_repeated (frame_repeated),
        .proto_err      (proto_err),
        .drop_cnt       (drop_cnt),
        .rep_cnt        (rep_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) ms[i] = S_FREE;
        mph = 0; m_wb = 0; m_exp = 0; m_act = 0; m_rb = 0; m_rv = 0;
        m_drop = 0; m_rep = 0; m_perr = 0; m_dcnt = 0; m_rcnt = 0;
    endtask

    // Phases: 0 idle, 1 long, 2 gap, 3 short. Writer effects apply before the reader's.
    task automatic model(input bit s, input bit e, input bit a, input bit r, input bit rs);
        int found;
        if (rs) begin
            model_reset();
            return;
        end
        m_drop = 0; m_rep = 0; m_perr = 0;
        if (a && mph != 0) begin
            ms[m_wb] = S_FREE; m_act = 0; m_exp = 0; mph = 0;
        end else begin
            case (mph)
                0: if (s) begin
                       found = -1;
                       for (int i = NB - 1; i >= 0; i--) if (ms[i] == S_FREE) found = i;
                       ms[found] = S_WRITING; m_wb = found; m_exp = 0; m_act = 1; mph = 1;
                   end else if (e) m_perr = 1;
                1: if (s) begin m_perr = 1; m_exp = 0; end
                   else if (e) mph = 2;
                2: if (s) begin m_exp = 1; mph = 3; end
                   else if (e) m_perr = 1;
                default: if (s) begin m_perr = 1; m_exp = 0; mph = 1; end
                   else if (e) begin
                       for (int i = 0; i < NB; i++)
                           if (ms[i] == S_READY) begin ms[i] = S_FREE; m_drop = 1; end
                       ms[m_wb] = S_READY; m_act = 0; m_exp = 0; mph = 0;
                   end
            endcase
        end
        if (r) begin
            found = -1;
            for (int i = 0; i < NB; i++) if (ms[i] == S_READY) found = i;
            if (found >= 0) begin
                for (int i = 0; i < NB; i++) if (ms[i] == S_READING) ms[i] = S_FREE;
                ms[found] = S_READING; m_rb = found; m_rv = 1;
            end else if (m_rv == 1) m_rep = 1;
        end
        if (m_drop == 1 && m_dcnt < 65535) m_dcnt++;
        if (m_rep == 1 && m_rcnt < 65535) m_rcnt++;
    endtask

    task automatic compare_all();
        chk("wr_buf", wr_buf, m_wb);
        chk("wr_exp", wr_exp, m_exp);
        chk("wr_active", wr_active, m_act);
        chk("rd_buf", rd_buf, m_rb);
        chk("rd_valid", rd_valid, m_rv);
        chk("frame_dropped", frame_dropped, m_drop);
        chk("frame_repeated", frame_repeated, m_rep);
        chk("proto_err", proto_err, m_perr);
        chk("drop_cnt", drop_cnt, m_dcnt);
        chk("rep_cnt", rep_cnt, m_rcnt);
        if (m_act == 1 && m_rv == 1)
            chk("slots_disjoint", wr_buf != rd_buf, 1);
    endtask

    task automatic step(input bit s, input bit e, input bit a, input bit r, input bit rs);
        @(negedge pixel_clk);
        wr_sof = s; wr_eof = e; wr_abort = a; rd_sof = r; reset = rs;
        model(s, e, a, r, rs);
        @(posedge pixel_clk);
        #1;
        compare_all();
    endtask

    task automatic pair(input bit rd_on_last);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, rd_on_last, 0);
    endtask

    initial begin
        bit s, e, a, r, rs;
        model_reset();

        step(0, 0, 0, 0, 1);
        chk("reset_rd_valid", rd_valid, 0);
        step(0, 0, 0, 1, 0);
        chk("empty_rd_no_repeat", frame_repeated, 0);

        step(1, 0, 0, 0, 0);
        chk("first_claim_slot", wr_buf, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("short_exposure", wr_exp, 1);
        step(0, 1, 0, 0, 0);
        chk("active_falls", wr_active, 0);
        step(0, 0, 0, 1, 0);
        chk("first_rd_buf", rd_buf, 0);

        step(0, 0, 0, 0, 1);
        pair(0);
        pair(0);
        chk("drop_pulse", frame_dropped, 1);
        chk("drop_cnt_one", drop_cnt, 1);
        step(0, 0, 0, 1, 0);
        chk("rd_newest", rd_buf, 1);
        step(0, 0, 0, 1, 0);
        chk("repeat_pulse", frame_repeated, 1);
        chk("rep_cnt_one", rep_cnt, 1);

        pair(1);
        chk("commit_and_read", rd_buf, 0);
        chk("commit_read_no_repeat", frame_repeated, 0);

        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("abort_inactive", wr_active, 0);
        step(1, 0, 0, 0, 0);
        chk("reclaim_slot", wr_buf, 1);
        step(1, 0, 0, 0, 0);
        chk("proto_restart", proto_err, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("reset_mid_short", wr_active, 0);
        step(0, 1, 0, 0, 0);
        chk("eof_idle_proto", proto_err, 1);

        for (int n = 0; n < 4000; n++) begin
            rs = ($urandom_range(0, 599) == 0);
            s  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 3) == 0);
            if (s && e) e = 0;
            a  = (mph != 0) && ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 5) == 0);
            step(s, e, a, r, rs);
        end
        step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
